// File: rtl/edge_generator_timer_pkg.sv
// Shared timer definitions: default widths, the per-channel slice offset
// helper and the edge action encoding used by both the output-compare
// edge generator and the input-capture edge detector.
package edge_generator_timer_pkg;

    localparam int DEF_WIDTH = 8;
    localparam int DEF_CNT_W = 16;
    localparam int DEF_PRE_W = 8;

    // Edge action decoded from the rising/falling match pair.
    typedef enum logic [1:0] {
        EDGE_NONE   = 2'b00,
        EDGE_RISE   = 2'b01,
        EDGE_FALL   = 2'b10,
        EDGE_TOGGLE = 2'b11
    } edge_action_e;

    // Low bit offset of channel ch inside a packed WIDTH*CNT_W bus.
    function automatic int unsigned chan_lo(input int unsigned ch, input int unsigned cnt_w);
        return ch * cnt_w;
    endfunction

    // Both matches at once means the channel toggles.
    function automatic edge_action_e edge_action(input logic rise, input logic fall);
        edge_action_e act;
        case ({fall, rise})
            2'b01:   act = EDGE_RISE;
            2'b10:   act = EDGE_FALL;
            2'b11:   act = EDGE_TOGGLE;
            default: act = EDGE_NONE;
        endcase
        return act;
    endfunction

endpackage

// File: rtl/edge_gen_channel.sv
// One output-compare channel: shadowed rise/fall compare values, match
// logic against the shared counter, the waveform flop and its edge pulse.
module edge_gen_channel
    import edge_generator_timer_pkg::*;
#(
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             tick,
    input  logic             copy,
    input  logic [CNT_W-1:0] count,
    input  logic [CNT_W-1:0] cmp_a_in,
    input  logic [CNT_W-1:0] cmp_b_in,
    input  logic             rise_en,
    input  logic             fall_en,
    output logic             signal,
    output logic             edge_generated
);

    logic [CNT_W-1:0] cmpa_act;
    logic [CNT_W-1:0] cmpb_act;
    logic             rise;
    logic             fall;
    edge_action_e     action;
    logic             signal_next;

    // Match against the current count and decode the level the pin takes next.
    always_comb begin
        rise        = rise_en && (count == cmpa_act);
        fall        = fall_en && (count == cmpb_act);
        action      = edge_action(rise, fall);
        signal_next = signal;
        case (action)
            EDGE_RISE:   signal_next = 1'b1;
            EDGE_FALL:   signal_next = 1'b0;
            EDGE_TOGGLE: signal_next = ~signal;
            default:     signal_next = signal;
        endcase
    end

    // Shadow compare registers, waveform flop and level-change pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            cmpa_act       <= '0;
            cmpb_act       <= '0;
            signal         <= 1'b0;
            edge_generated <= 1'b0;
        end else begin
            if (copy) begin
                cmpa_act <= cmp_a_in;
                cmpb_act <= cmp_b_in;
            end
            if (tick) begin
                signal <= signal_next;
            end
            edge_generated <= tick && (signal_next != signal);
        end
    end

endmodule

// File: rtl/edge_generator_timer.sv
// Timer output-compare block: a shared up-counter with double-buffered
// period and per-channel compare values drives WIDTH waveform pins.
// Optional build macro EDGE_GEN_PRESCALE_EN adds a prescale input that
// divides the enabled clock into counter ticks.
module edge_generator_timer
    import edge_generator_timer_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int CNT_W = DEF_CNT_W,
    parameter int PRE_W = DEF_PRE_W
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   enable,
`ifdef EDGE_GEN_PRESCALE_EN
    input  logic [PRE_W-1:0]       prescale,
`endif
    input  logic                   load,
    input  logic [CNT_W-1:0]       period,
    input  logic [WIDTH*CNT_W-1:0] cmp_a,
    input  logic [WIDTH*CNT_W-1:0] cmp_b,
    input  logic [WIDTH-1:0]       EDGEnA,
    input  logic [WIDTH-1:0]       EDGEnB,
    output logic [WIDTH-1:0]       signal,
    output logic [WIDTH-1:0]       edge_generated,
    output logic [CNT_W-1:0]       count,
    output logic                   wrap
);

    logic             tick;
    logic             at_term;
    logic             copy;
    logic             load_pending;
    logic [CNT_W-1:0] period_act;

`ifdef EDGE_GEN_PRESCALE_EN
    logic [PRE_W-1:0] pre_cnt;
    logic             pre_hit;

    // A '>=' hit keeps the divider bounded if prescale is lowered mid-count.
    assign pre_hit = (pre_cnt >= prescale);
    assign tick    = enable && pre_hit;

    // Prescale counter: runs 0..prescale while enabled, holds otherwise.
    always_ff @(posedge clk) begin
        if (rst) begin
            pre_cnt <= '0;
        end else if (enable) begin
            pre_cnt <= pre_hit ? '0 : pre_cnt + PRE_W'(1);
        end
    end
`else
    assign tick = enable;
`endif

    assign at_term = (count == period_act);

    // Shadow copy happens at the wrap tick (a load arriving in that same
    // cycle counts), or on the next clock if the timer is stopped with a
    // load still pending so software does not wait on a frozen counter.
    assign copy = (tick && at_term && (load || load_pending)) ||
                  (!enable && load_pending);

    // Counter, wrap pulse, active period and pending-load flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            count        <= '0;
            wrap         <= 1'b0;
            period_act   <= '0;
            load_pending <= 1'b0;
        end else begin
            wrap <= tick && at_term;
            if (tick) begin
                count <= at_term ? '0 : count + CNT_W'(1);
            end
            if (copy) begin
                period_act <= period;
            end
            if (copy) begin
                load_pending <= 1'b0;
            end else if (load) begin
                load_pending <= 1'b1;
            end
        end
    end

    for (genvar i = 0; i < WIDTH; i++) begin : g_chan
        edge_gen_channel #(
            .CNT_W(CNT_W)
        ) u_chan (
            .clk            (clk),
            .rst            (rst),
            .tick           (tick),
            .copy           (copy),
            .count          (count),
            .cmp_a_in       (cmp_a[chan_lo(i, CNT_W) +: CNT_W]),
            .cmp_b_in       (cmp_b[chan_lo(i, CNT_W) +: CNT_W]),
            .rise_en        (EDGEnA[i]),
            .fall_en        (EDGEnB[i]),
            .signal         (signal[i]),
            .edge_generated (edge_generated[i])
        );
    end

endmodule

// File: tb/tb_edge_generator_timer.sv
// Directed bench for edge_generator_timer with WIDTH=2, CNT_W=8.
// Inputs change 1ns after the rising edge; outputs are checked there too.
module tb_edge_generator_timer;

    localparam int WIDTH = 2;
    localparam int CNT_W = 8;
    localparam int PRE_W = 8;

    logic                   clk = 1'b0;
    logic                   rst;
    logic                   enable;
    logic [PRE_W-1:0]       prescale;
    logic                   load;
    logic [CNT_W-1:0]       period;
    logic [WIDTH*CNT_W-1:0] cmp_a;
    logic [WIDTH*CNT_W-1:0] cmp_b;
    logic [WIDTH-1:0]       edge_a_en;
    logic [WIDTH-1:0]       edge_b_en;
    logic [WIDTH-1:0]       signal;
    logic [WIDTH-1:0]       edge_generated;
    logic [CNT_W-1:0]       count;
    logic                   wrap;

    int n_checks = 0;
    int n_fail   = 0;

    edge_generator_timer #(
        .WIDTH(WIDTH),
        .CNT_W(CNT_W),
        .PRE_W(PRE_W)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .enable         (enable),
`ifdef EDGE_GEN_PRESCALE_EN
        .prescale       (prescale),
`endif
        .load           (load),
        .period         (period),
        .cmp_a          (cmp_a),
        .cmp_b          (cmp_b),
        .EDGEnA         (edge_a_en),
        .EDGEnB         (edge_b_en),
        .signal         (signal),
        .edge_generated (edge_generated),
        .count          (count),
        .wrap           (wrap)
    );

    // Clock and watchdog
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d failures=%0d", n_checks, n_fail + 1);
        $fatal(1, "watchdog");
    end

    // Driver tasks
    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic set_cmp(input int ch, input int a, input int b);
        cmp_a[ch*CNT_W +: CNT_W] = CNT_W'(a);
        cmp_b[ch*CNT_W +: CNT_W] = CNT_W'(b);
    endtask

    // Request a shadow load while stopped: pending on the first clock, copy on the second.
    task automatic load_stopped();
        enable = 1'b0;
        load   = 1'b1;
        cycle();
        load   = 1'b0;
        cycle();
    endtask

    task automatic test_reset();
        rst = 1'b1; enable = 1'b0; load = 1'b0; prescale = '0;
        period = '0; cmp_a = '0; cmp_b = '0; edge_a_en = '0; edge_b_en = '0;
        cycle();
        cycle();
        rst = 1'b0;
        n_checks++; if (count !== 8'd0) begin n_fail++; $display("FAIL reset_count: got %0d expected 0", count); end
        n_checks++; if (signal !== 2'b00) begin n_fail++; $display("FAIL reset_signal: got %b expected 00", signal); end
        n_checks++; if (edge_generated !== 2'b00) begin n_fail++; $display("FAIL reset_edge: got %b expected 00", edge_generated); end
        n_checks++; if (wrap !== 1'b0) begin n_fail++; $display("FAIL reset_wrap: got %b expected 0", wrap); end
    endtask

    // ch0: rise at 2, fall at 6; ch1: rise and fall both at 4 -> toggle.
    task automatic test_pwm();
        int k, p;
        logic e_sig0, e_edge0, e_sig1, e_edge1, e_wrap;
        period = 8'd9;
        set_cmp(0, 2, 6);
        set_cmp(1, 4, 4);
        edge_a_en = 2'b11;
        edge_b_en = 2'b11;
        load_stopped();
        enable = 1'b1;
        for (int i = 0; i < 30; i++) begin
            cycle();
            k = (i + 1) % 10;
            p = (i + 1) / 10;
            e_sig0  = (k >= 3 && k <= 6);
            e_edge0 = (k == 3 || k == 7);
            e_sig1  = ((p + ((k >= 5) ? 1 : 0)) % 2) == 1;
            e_edge1 = (k == 5);
            e_wrap  = (k == 0);
            n_checks++; if (count !== 8'(k)) begin n_fail++; $display("FAIL pwm_count i=%0d: got %0d expected %0d", i, count, k); end
            n_checks++; if (signal[0] !== e_sig0) begin n_fail++; $display("FAIL pwm_sig0 i=%0d: got %b expected %b", i, signal[0], e_sig0); end
            n_checks++; if (edge_generated[0] !== e_edge0) begin n_fail++; $display("FAIL pwm_edge0 i=%0d: got %b expected %b", i, edge_generated[0], e_edge0); end
            n_checks++; if (signal[1] !== e_sig1) begin n_fail++; $display("FAIL toggle_sig1 i=%0d: got %b expected %b", i, signal[1], e_sig1); end
            n_checks++; if (edge_generated[1] !== e_edge1) begin n_fail++; $display("FAIL toggle_edge1 i=%0d: got %b expected %b", i, edge_generated[1], e_edge1); end
            n_checks++; if (wrap !== e_wrap) begin n_fail++; $display("FAIL pwm_wrap i=%0d: got %b expected %b", i, wrap, e_wrap); end
        end
    endtask

    // Counter is at 0 here. New cmp_a=5 must wait for the next wrap.
    task automatic test_double_buffer();
        int k;
        logic newp, e_sig0, e_edge0;
        set_cmp(0, 5, 6);
        load = 1'b1;
        for (int i = 0; i < 20; i++) begin
            cycle();
            load = 1'b0;
            k = (i + 1) % 10;
            newp = (i >= 9);
            e_sig0  = newp ? (k == 6) : (k >= 3 && k <= 6);
            e_edge0 = newp ? (k == 6 || k == 7) : (k == 3 || k == 7);
            n_checks++; if (count !== 8'(k)) begin n_fail++; $display("FAIL dbuf_count i=%0d: got %0d expected %0d", i, count, k); end
            n_checks++; if (signal[0] !== e_sig0) begin n_fail++; $display("FAIL dbuf_sig0 i=%0d: got %b expected %b", i, signal[0], e_sig0); end
            n_checks++; if (edge_generated[0] !== e_edge0) begin n_fail++; $display("FAIL dbuf_edge0 i=%0d: got %b expected %b", i, edge_generated[0], e_edge0); end
        end
    endtask

    // Load raised during the terminal-count cycle takes effect at that wrap.
    task automatic test_load_at_wrap();
        for (int i = 0; i < 9; i++) cycle();
        set_cmp(0, 7, 6);
        load = 1'b1;
        cycle();
        load = 1'b0;
        n_checks++; if (count !== 8'd0) begin n_fail++; $display("FAIL lwrap_count: got %0d expected 0", count); end
        n_checks++; if (wrap !== 1'b1) begin n_fail++; $display("FAIL lwrap_wrap: got %b expected 1", wrap); end
        n_checks++; if (signal[0] !== 1'b0) begin n_fail++; $display("FAIL lwrap_sig0_at_wrap: got %b expected 0", signal[0]); end
        for (int j = 1; j < 10; j++) begin
            cycle();
            n_checks++; if (count !== 8'(j)) begin n_fail++; $display("FAIL lwrap_count j=%0d: got %0d expected %0d", j, count, j); end
            n_checks++; if (signal[0] !== (j >= 8)) begin n_fail++; $display("FAIL lwrap_sig0 j=%0d: got %b expected %b", j, signal[0], (j >= 8)); end
            n_checks++; if (edge_generated[0] !== (j == 8)) begin n_fail++; $display("FAIL lwrap_edge0 j=%0d: got %b expected %b", j, edge_generated[0], (j == 8)); end
        end
    endtask

    // Compare values above the period never match; stopped counter holds.
    task automatic test_cmp_beyond_period();
        int k;
        set_cmp(0, 12, 12);
        load_stopped();
        n_checks++; if (count !== 8'd9) begin n_fail++; $display("FAIL stop_count: got %0d expected 9", count); end
        n_checks++; if (wrap !== 1'b0) begin n_fail++; $display("FAIL stop_wrap: got %b expected 0", wrap); end
        n_checks++; if (edge_generated !== 2'b00) begin n_fail++; $display("FAIL stop_edge: got %b expected 00", edge_generated); end
        enable = 1'b1;
        for (int i = 0; i < 25; i++) begin
            cycle();
            k = i % 10;
            n_checks++; if (count !== 8'(k)) begin n_fail++; $display("FAIL big_count i=%0d: got %0d expected %0d", i, count, k); end
            n_checks++; if (wrap !== (k == 0)) begin n_fail++; $display("FAIL big_wrap i=%0d: got %b expected %b", i, wrap, (k == 0)); end
            n_checks++; if (edge_generated[0] !== 1'b0) begin n_fail++; $display("FAIL big_edge0 i=%0d: got %b expected 0", i, edge_generated[0]); end
            n_checks++; if (signal[0] !== 1'b1) begin n_fail++; $display("FAIL big_sig0 i=%0d: got %b expected 1", i, signal[0]); end
        end
    endtask

    // Reset at count=5 with a load pending, then run on the all-zero
    // active registers: period 0, cmp_a 0.
    task automatic test_reset_mid_and_period0();
        logic found;
        set_cmp(0, 2, 6);
        load_stopped();
        enable = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 30 && !found; i++) begin
            cycle();
            if (count == 8'd4) found = 1'b1;
        end
        n_checks++; if (found !== 1'b1) begin n_fail++; $display("FAIL rmid_wait: count reached=%b expected 1", found); end
        set_cmp(0, 3, 6);
        load = 1'b1;
        cycle();
        load = 1'b0;
        n_checks++; if (count !== 8'd5) begin n_fail++; $display("FAIL rmid_count: got %0d expected 5", count); end
        n_checks++; if (signal[0] !== 1'b1) begin n_fail++; $display("FAIL rmid_sig0: got %b expected 1", signal[0]); end
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        n_checks++; if (count !== 8'd0) begin n_fail++; $display("FAIL rmid_rst_count: got %0d expected 0", count); end
        n_checks++; if (signal !== 2'b00) begin n_fail++; $display("FAIL rmid_rst_signal: got %b expected 00", signal); end
        n_checks++; if (edge_generated !== 2'b00) begin n_fail++; $display("FAIL rmid_rst_edge: got %b expected 00", edge_generated); end
        n_checks++; if (wrap !== 1'b0) begin n_fail++; $display("FAIL rmid_rst_wrap: got %b expected 0", wrap); end
        edge_a_en = 2'b01;
        edge_b_en = 2'b00;
        enable = 1'b0;
        cycle();
        cycle();
        enable = 1'b1;
        for (int i = 0; i < 4; i++) begin
            cycle();
            n_checks++; if (count !== 8'd0) begin n_fail++; $display("FAIL p0_count i=%0d: got %0d expected 0", i, count); end
            n_checks++; if (wrap !== 1'b1) begin n_fail++; $display("FAIL p0_wrap i=%0d: got %b expected 1", i, wrap); end
            n_checks++; if (signal !== 2'b01) begin n_fail++; $display("FAIL p0_signal i=%0d: got %b expected 01", i, signal); end
            n_checks++; if (edge_generated[0] !== (i == 0)) begin n_fail++; $display("FAIL p0_edge0 i=%0d: got %b expected %b", i, edge_generated[0], (i == 0)); end
        end
    endtask

`ifdef EDGE_GEN_PRESCALE_EN
    // prescale=2, period=3: count steps every 3 cycles, wrap every 12.
    task automatic test_prescale();
        int e;
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        prescale = 8'd2;
        period = 8'd3;
        edge_a_en = '0;
        edge_b_en = '0;
        load_stopped();
        enable = 1'b1;
        for (int n = 1; n <= 25; n++) begin
            cycle();
            e = (n / 3) % 4;
            n_checks++; if (count !== 8'(e)) begin n_fail++; $display("FAIL pre_count n=%0d: got %0d expected %0d", n, count, e); end
            n_checks++; if (wrap !== ((n % 12) == 0)) begin n_fail++; $display("FAIL pre_wrap n=%0d: got %b expected %b", n, wrap, ((n % 12) == 0)); end
        end
        enable = 1'b0;
        for (int i = 0; i < 4; i++) begin
            cycle();
            n_checks++; if (count !== 8'd0) begin n_fail++; $display("FAIL pre_hold_count i=%0d: got %0d expected 0", i, count); end
            n_checks++; if (wrap !== 1'b0) begin n_fail++; $display("FAIL pre_hold_wrap i=%0d: got %b expected 0", i, wrap); end
        end
        enable = 1'b1;
        cycle();
        n_checks++; if (count !== 8'd0) begin n_fail++; $display("FAIL pre_resume1: got %0d expected 0", count); end
        cycle();
        n_checks++; if (count !== 8'd1) begin n_fail++; $display("FAIL pre_resume2: got %0d expected 1", count); end
    endtask
`endif

    // Test sequence and final report
    initial begin
        test_reset();
        test_pwm();
        test_double_buffer();
        test_load_at_wrap();
        test_cmp_beyond_period();
        test_reset_mid_and_period0();
`ifdef EDGE_GEN_PRESCALE_EN
        test_prescale();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
